// File: rtl/ila_pkg.sv
// Shared constants and state encoding for the logic-analyzer capture and readout paths.
package ila_pkg;

  localparam int unsigned ILA_DEPTH = 256;
  localparam int unsigned ILA_AW    = 8;
  localparam int unsigned ILA_DW    = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StValid = 2'd2
  } ila_state_e;

endpackage

// File: rtl/ila_readout.sv
// Readout engine: walks the circular capture RAM from the oldest sample and streams
// each sample over valid/ready, one sample per clock when the sink keeps up.
module ila_readout
  import ila_pkg::*;
#(
  parameter int unsigned DEPTH = ILA_DEPTH,
  parameter int unsigned AW    = ILA_AW,
  parameter int unsigned DW    = ILA_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW-1:0] i_wr_ptr,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_m_data,
  output logic [AW-1:0] o_m_index,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic          o_m_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  ila_state_e    r_state, w_state_d;
  logic [AW-1:0] r_base, r_cnt, r_index;
  logic [DW-1:0] r_data;
  logic          r_valid, r_last, r_busy, r_done, r_fresh;

  logic          w_adv, w_fin, w_mem_re;
  logic [AW-1:0] w_rd_cnt, w_rd_addr;

  always_comb begin
    w_adv     = (r_state == StValid) && i_m_ready && !r_last;
    w_fin     = (r_state == StValid) && i_m_ready && r_last;
    w_mem_re  = (r_state == StRead) || w_adv;
    w_rd_cnt  = w_adv ? (r_cnt + AW'(1)) : r_cnt;
    w_rd_addr = r_base + w_rd_cnt;
  end

  always_comb begin
    w_state_d = r_state;
    if (i_abort) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (i_start) w_state_d = StRead;
        StRead:  w_state_d = StValid;
        StValid: if (w_fin) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_cnt   <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d != StIdle);
      r_done  <= w_fin && !i_abort;
      // Data from a read issued in an abort cycle is never marked fresh, so it is dropped.
      r_fresh <= w_mem_re && !i_abort;
      if (r_fresh) r_data <= i_mem_rdata;
      if (i_abort) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_base <= i_wr_ptr;
              r_cnt  <= '0;
            end
          end
          StRead: begin
            r_valid <= 1'b1;
            r_index <= r_cnt;
            r_last  <= (r_cnt == LastIdx);
          end
          StValid: begin
            if (w_adv) begin
              r_cnt   <= w_rd_cnt;
              r_index <= w_rd_cnt;
              r_last  <= (w_rd_cnt == LastIdx);
            end else if (w_fin) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The RAM word is only present in the cycle after the read; hold it locally afterwards.
  assign o_m_data   = r_fresh ? i_mem_rdata : r_data;
  assign o_mem_re   = w_mem_re;
  assign o_mem_addr = w_mem_re ? w_rd_addr : '0;
  assign o_m_index  = r_index;
  assign o_m_valid  = r_valid;
  assign o_m_last   = r_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_ila_readout.sv
// Self-checking bench for ila_readout: table-driven full readouts, corner-case sequences
// and randomized runs checked against a sample-order model of the circular buffer.
module tb_ila_readout;

  logic        clk, rst_n, start, abort, m_ready;
  logic [7:0]  wr_ptr, mem_addr, m_index;
  logic        mem_re, m_valid, m_last, busy, done;
  logic [15:0] mem_rdata, m_data;
  logic [15:0] ram [256];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] acc_q[$];
  logic [7:0]  addr_q[$];

  typedef struct {
    logic [7:0]  base;
    int          mode;
    logic [15:0] first, d16, d17, last;
  } vec_t;
  vec_t tbl [5];

  ila_readout dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_wr_ptr(wr_ptr),
    .o_mem_re(mem_re), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_m_data(m_data), .o_m_index(m_index), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_last(m_last), .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sample RAM, 1-cycle latency.
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_re"},   32'(mem_re),   0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_m_data"},   32'(m_data),   0);
    chk({tag, "_m_index"},  32'(m_index),  0);
    chk({tag, "_m_valid"},  32'(m_valid),  0);
    chk({tag, "_m_last"},   32'(m_last),   0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_done"},     32'(done),     0);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    logic [4:0] pat;
    pat = 5'b01001;  // bit i = ready in cycle i: 1,0,0,1,0
    case (mode)
      0:       return 1'b1;
      1:       return pat[cyc % 5];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // ev_kind: 0 none, 1 start+new wr_ptr while busy, 2 abort (with start), 3 reset.
  task automatic run_stream(input logic [7:0] base, input int mode, input int ev_kind,
                            input int ev_idx);
    int k, cyc, last_acc, done_cnt, addr_bad;
    logic stop, fire, prev_hold, rdy, pl;
    logic [15:0] pd;
    logic [7:0]  pi;
    acc_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    wr_ptr = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_ptr = 8'($urandom);
    k = 0; cyc = 0; last_acc = -10; done_cnt = 0; stop = 0; fire = 0; prev_hold = 0;
    pd = '0; pi = '0; pl = 0;
    while (!stop && cyc < 3000) begin
      rdy = ready_for(mode, cyc);
      m_ready = rdy;
      if (fire && ev_kind == 1) begin
        start = 1'b1; wr_ptr = 8'h80; fire = 0;
      end
      if (fire && ev_kind == 2) begin
        abort = 1'b1; start = 1'b1; wr_ptr = 8'h33;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(m_valid), 0);
        chk("abort_last", 32'(m_last), 0);
        chk("abort_mem_re", 32'(mem_re), 0);
        chk("abort_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_idle_done", 32'(done), 0);
          chk("abort_idle_busy", 32'(busy), 0);
        end
        return;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("lat_mem_re", 32'(mem_re), 1);
        chk("lat_addr", 32'(mem_addr), 32'(base));
        chk("lat_valid0", 32'(m_valid), 0);
        chk("lat_busy", 32'(busy), 1);
      end
      if (cyc == 1) chk("lat_valid1", 32'(m_valid), 1);
      if (mem_re) begin
        addr_q.push_back(mem_addr);
        if (busy !== 1'b1) chk("re_outside_busy", 32'(busy), 1);
      end
      if (prev_hold && m_valid) begin
        chk("hold_data", 32'(m_data), 32'(pd));
        chk("hold_index", 32'(m_index), 32'(pi));
        chk("hold_last", 32'(m_last), 32'(pl));
      end
      prev_hold = m_valid && !rdy;
      pd = m_data; pi = m_index; pl = m_last;
      if (m_valid && rdy) begin
        if (k >= 256) chk("extra_sample", 32'(k), 255);
        chk("data", 32'(m_data), 32'(ram[8'(base + 8'(k))]));
        chk("index", 32'(m_index), 32'(k[7:0]));
        chk("last", 32'(m_last), 32'(k == 255));
        acc_q.push_back(m_data);
        if (ev_kind != 0 && k == ev_idx) fire = 1;
        k++;
        last_acc = cyc;
        if (fire && ev_kind == 3) begin
          rst_n = 1'b0;
          #1;
          chk_zero("rst_mid");
          @(posedge clk); @(posedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_zero("rst_after");
          end
          return;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 32'(cyc), 32'(last_acc + 1));
        chk("done_busy", 32'(busy), 0);
        stop = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("accept_count", 32'(k), 256);
    chk("done_count", 32'(done_cnt), 1);
    addr_bad = 0;
    foreach (addr_q[i]) if (addr_q[i] !== 8'(base + 8'(i))) addr_bad++;
    chk("addr_count", 32'(addr_q.size()), 256);
    chk("addr_seq", 32'(addr_bad), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0; wr_ptr = '0;
    for (int a = 0; a < 256; a++) ram[a] = 16'(a);

    tbl[0] = '{base: 8'h00, mode: 0, first: 16'h00, d16: 16'h0F, d17: 16'h10, last: 16'hFF};
    tbl[1] = '{base: 8'hF0, mode: 0, first: 16'hF0, d16: 16'hFF, d17: 16'h00, last: 16'hEF};
    tbl[2] = '{base: 8'hFF, mode: 0, first: 16'hFF, d16: 16'h0E, d17: 16'h0F, last: 16'hFE};
    tbl[3] = '{base: 8'h00, mode: 1, first: 16'h00, d16: 16'h0F, d17: 16'h10, last: 16'hFF};
    tbl[4] = '{base: 8'h5A, mode: 2, first: 16'h5A, d16: 16'h69, d17: 16'h6A, last: 16'h59};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end

    foreach (tbl[i]) begin
      run_stream(tbl[i].base, tbl[i].mode, 0, 0);
      if (acc_q.size() == 256) begin
        chk("vec_first", 32'(acc_q[0]), 32'(tbl[i].first));
        chk("vec_16th", 32'(acc_q[15]), 32'(tbl[i].d16));
        chk("vec_17th", 32'(acc_q[16]), 32'(tbl[i].d17));
        chk("vec_last", 32'(acc_q[255]), 32'(tbl[i].last));
      end else begin
        chk("vec_size", 32'(acc_q.size()), 256);
      end
    end

    run_stream(8'h20, 0, 1, 50);
    run_stream(8'h00, 0, 2, 100);
    run_stream(8'h10, 0, 0, 0);
    if (acc_q.size() > 0) chk("post_abort_first", 32'(acc_q[0]), 32'h0010);
    else chk("post_abort_size", 32'(acc_q.size()), 256);
    run_stream(8'h40, 0, 3, 120);
    run_stream(8'hC3, 1, 0, 0);

    for (int a = 0; a < 256; a++) ram[a] = 16'($urandom);
    for (int r = 0; r < 3; r++) run_stream(8'($urandom), 2, 0, 0);
    run_stream(8'($urandom), 1, 1, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ila_readout.md
Name: ila_readout

Overview:
- Read-side engine for the logic analyzer's circular capture memory.
- After a capture completes, `ila_readout` walks the sample RAM from the oldest sample to the newest, starting at the frozen write pointer and wrapping modulo DEPTH.
- It streams each sample over a valid/ready interface to the VGA waveform renderer.
- It is the consumer counterpart of the capture-side address counter.

Parameters:
- DEPTH, 256, number of samples in the capture RAM; must be a power of two.
- AW, 8, address width; AW = log2(DEPTH).
- DW, 16, sample width in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a readout; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- wr_ptr  in  AW  capture write pointer (address of the oldest sample); latched on accepted start.
- mem_re  out  1  RAM read enable.
- mem_addr  out  AW  RAM read address.
- mem_rdata  in  DW  RAM read data; valid exactly 1 cycle after mem_re.
- m_data  out  DW  output sample.
- m_index  out  AW  sample index (0 = oldest).
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high with the sample where m_index = DEPTH-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_re, mem_addr, m_data, m_index, m_valid, m_last, busy, done.
  - Internal base pointer and counter are cleared.
- States: IDLE, READ, VALID.
- IDLE:
  - When start = 1 and abort = 0: latch base <= wr_ptr, set cnt <= 0, go to READ.
  - The start cycle drives no read.
- READ:
  - mem_re = 1 and mem_addr = base + cnt (AW-bit add, wraps naturally).
  - Next cycle: m_data <= mem_rdata, m_index <= cnt, m_last <= (cnt == DEPTH-1), m_valid <= 1; go to VALID.
- VALID:
  - m_valid = 1. m_data, m_index and m_last are held stable while m_ready = 0; none may change until accepted.
  - On m_ready = 1 with m_last = 0:
    - Same cycle: cnt <= cnt+1, mem_re = 1, mem_addr = base + cnt + 1.
    - Next cycle: the new sample loads, m_valid stays 1.
    - Sustained throughput is one sample per clock while m_ready is held high.
  - On m_ready = 1 with m_last = 1: m_valid <= 0, done pulses 1 the next cycle, go to IDLE.
- mem_re is combinational from state, m_ready and m_last, and is never asserted in IDLE.
- Latency: start accepted at cycle T gives mem_re at T+1 and first m_valid at T+2.
- Total accepted samples per readout is exactly DEPTH.
- Address wrap:
  - With base = DEPTH-1, the second read address is 0.
  - No sample is skipped or repeated.
- start while busy is ignored; base is not re-latched.
- abort (any state) takes effect next cycle:
  - State goes to IDLE; m_valid, m_last and mem_re go to 0.
  - No done pulse.
  - abort has priority over start and over m_ready in the same cycle.
- A read issued in the abort cycle returns data that is discarded.
- wr_ptr changes after start have no effect on the current readout.
- busy = (state != IDLE), registered.
- The done cycle is IDLE (busy = 0), so a start in that same cycle is accepted.
- Reset asserted mid-stream clears everything immediately. After release the block idles until a new start.

Decomposition:
- Shared package ila_pkg holds:
  - state encoding constants: IDLE = 2'd0, READ = 2'd1, VALID = 2'd2;
  - the default DEPTH/AW/DW constants shared with the capture side and the sample RAM.
- No sub-module. The pointer arithmetic is a plain AW-bit adder and the counter is inline.
- The sample RAM stays external. Its interface is a 1-cycle synchronous read.

Test Plan:
- Reset and idle: hold rst = 0 for 3 cycles, then release with no start. Required: all outputs stay 0 and mem_re is never asserted.
- Full stream, ready always high: RAM[i] = i, DEPTH = 256, wr_ptr = 0x00, start pulse. Required:
  - 256 consecutive m_valid cycles;
  - m_data = 0..255 and m_index = 0..255;
  - m_last only on index 255;
  - done exactly once, one cycle after the last accept.
- Wrap-around: wr_ptr = 0xF0, RAM[a] = a. Required:
  - mem_addr sequence F0..FF, 00..EF;
  - m_data first = 0xF0, 16th = 0xFF, 17th = 0x00, last = 0xEF.
- Backpressure: toggle m_ready with the pattern 1,0,0,1,0 repeating. Required:
  - m_data, m_index and m_last stable whenever m_valid = 1 and m_ready = 0;
  - no sample lost or duplicated;
  - all 256 delivered in order.
- Abort mid-stream: abort after index 100 is accepted, with start asserted in the same cycle. Required:
  - next cycle busy = 0, m_valid = 0, no done;
  - a later start with wr_ptr = 0x10 yields first m_data = RAM[0x10].
- Start during busy and reset mid-operation:
  - A start pulse at index 50 with wr_ptr changed to 0x80. Required: the stream continues from the original base unaffected.
  - rst = 0 asserted at index 120. Required: all outputs 0 immediately, state IDLE after release.
